// File: rtl/riscv_mem_pkg.sv
// Shared decode constants, exception cause codes and FSM state type
// for the RV64 memory-access stage.
package riscv_mem_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_align_unit.sv
// Combinational alignment helper: misalignment detection, store byte-lane
// placement and load extraction with sign/zero extension.
module mem_align_unit
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic [2:0]  i_off,
  input  logic [63:0] i_sr2,
  input  logic [63:0] i_rdata,
  output logic        o_misalign,
  output logic [7:0]  o_wmask,
  output logic [63:0] o_wdata,
  output logic [63:0] o_ldata
);

  logic [7:0]  w_size_mask;
  logic [63:0] w_shifted;
  logic        w_sext;

  always_comb begin
    w_size_mask = 8'hFF;
    o_misalign  = 1'b0;
    case (i_f3[1:0])
      SZ_B: begin w_size_mask = 8'h01; o_misalign = 1'b0;        end
      SZ_H: begin w_size_mask = 8'h03; o_misalign = i_off[0];    end
      SZ_W: begin w_size_mask = 8'h0F; o_misalign = |i_off[1:0]; end
      default: begin w_size_mask = 8'hFF; o_misalign = |i_off;   end
    endcase
  end

  assign o_wmask   = w_size_mask << i_off;
  assign o_wdata   = i_sr2 << {i_off, 3'b000};
  assign w_shifted = i_rdata >> {i_off, 3'b000};
  assign w_sext    = ~i_f3[2];

  always_comb begin
    o_ldata = w_shifted;
    case (i_f3[1:0])
      SZ_B: o_ldata = {{56{w_sext & w_shifted[7]}},  w_shifted[7:0]};
      SZ_H: o_ldata = {{48{w_sext & w_shifted[15]}}, w_shifted[15:0]};
      SZ_W: o_ldata = {{32{w_sext & w_shifted[31]}}, w_shifted[31:0]};
      default: o_ldata = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory-access stage: issues dmem requests over req/ack, stalls execute
// while waiting, and registers results/exceptions into the writeback bundle.
module mem_stage
  import riscv_mem_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_V,
  input  logic [31:0]     mem_IR,
  input  logic [XLEN-1:0] mem_PC,
  input  logic [XLEN-1:0] mem_ALU_RESULT,
  input  logic [XLEN-1:0] mem_SR1,
  input  logic [XLEN-1:0] mem_SR2,
  input  logic [XLEN-1:0] mem_CSRFD,
  input  logic [XLEN-1:0] mem_RFD,
  output logic            mem_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wmask,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_V,
  output logic [31:0]     wb_IR,
  output logic [XLEN-1:0] wb_PC,
  output logic [XLEN-1:0] wb_ALU_RESULT,
  output logic [XLEN-1:0] wb_CSRFD,
  output logic [XLEN-1:0] wb_RFD,
  output logic [XLEN-1:0] wb_MEM_RESULT,
  output logic            wb_EXC,
  output logic [3:0]      wb_EXC_CAUSE
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  mem_state_e  r_state, w_state_next;
  logic [7:0]  r_cnt;

  logic        w_is_load, w_is_store, w_illegal, w_misalign;
  logic        w_mem_go, w_exc_imm, w_timeout;
  logic [3:0]  w_cause_imm;
  logic [7:0]  w_wmask;
  logic [63:0] w_wdata, w_ldata;
  logic        w_unused_sr1;

  assign w_unused_sr1 = ^mem_SR1;

  assign w_is_load  = (mem_IR[6:0] == OP_LOAD);
  assign w_is_store = (mem_IR[6:0] == OP_STORE);
  assign w_illegal  = (w_is_load && mem_IR[14:12] == 3'b111) || (w_is_store && mem_IR[14]);

  mem_align_unit u_align (
    .i_f3       (mem_IR[14:12]),
    .i_off      (mem_ALU_RESULT[2:0]),
    .i_sr2      (mem_SR2),
    .i_rdata    (dmem_rdata),
    .o_misalign (w_misalign),
    .o_wmask    (w_wmask),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata)
  );

  assign w_mem_go    = mem_V && (w_is_load || w_is_store) && !w_illegal && !w_misalign;
  assign w_exc_imm   = mem_V && (w_is_load || w_is_store) && (w_illegal || w_misalign);
  assign w_cause_imm = w_illegal ? CAUSE_ILLEGAL :
                       (w_is_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN);
  // Fault fires once TIMEOUT_CYCLES ack-less ACCESS cycles have elapsed; ack still wins that cycle.
  assign w_timeout   = (r_cnt == TIMEOUT_LIMIT);

  always_comb begin
    w_state_next = r_state;
    mem_stall    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_go) begin
          w_state_next = S_ACCESS;
          mem_stall    = 1'b1;
        end
      end
      S_ACCESS: begin
        if (dmem_ack || w_timeout) w_state_next = S_IDLE;
        else                        mem_stall    = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 8'd0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_wmask    <= 8'd0;
      wb_V          <= 1'b0;
      wb_IR         <= 32'd0;
      wb_PC         <= '0;
      wb_ALU_RESULT <= '0;
      wb_CSRFD      <= '0;
      wb_RFD        <= '0;
      wb_MEM_RESULT <= '0;
      wb_EXC        <= 1'b0;
      wb_EXC_CAUSE  <= 4'd0;
    end else begin
      r_state       <= w_state_next;
      // execute holds the bundle stable during ACCESS, so pass-through is safe every cycle
      wb_IR         <= mem_IR;
      wb_PC         <= mem_PC;
      wb_ALU_RESULT <= mem_ALU_RESULT;
      wb_CSRFD      <= mem_CSRFD;
      wb_RFD        <= mem_RFD;
      wb_MEM_RESULT <= '0;
      wb_EXC        <= 1'b0;
      wb_EXC_CAUSE  <= 4'd0;
      case (r_state)
        S_IDLE: begin
          if (w_mem_go) begin
            wb_V       <= 1'b0;
            r_cnt      <= 8'd0;
            dmem_req   <= 1'b1;
            dmem_we    <= w_is_store;
            dmem_addr  <= {mem_ALU_RESULT[XLEN-1:3], 3'b000};
            dmem_wdata <= w_is_store ? w_wdata : 64'd0;
            dmem_wmask <= w_is_store ? w_wmask : 8'd0;
          end else begin
            wb_V         <= mem_V;
            wb_EXC       <= w_exc_imm;
            wb_EXC_CAUSE <= w_exc_imm ? w_cause_imm : 4'd0;
          end
        end
        S_ACCESS: begin
          if (dmem_ack || w_timeout) begin
            wb_V       <= 1'b1;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wmask <= 8'd0;
            if (dmem_ack) begin
              wb_MEM_RESULT <= w_is_load ? w_ldata : 64'd0;
            end else begin
              wb_EXC       <= 1'b1;
              wb_EXC_CAUSE <= w_is_store ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
            end
          end else begin
            wb_V  <= 1'b0;
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: wb_V <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level
// reference model of load/store alignment, stall counts and exceptions.
module tb_mem_stage;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_V;
  logic [31:0] mem_IR;
  logic [63:0] mem_PC, mem_ALU_RESULT, mem_SR1, mem_SR2, mem_CSRFD, mem_RFD;
  logic        mem_stall, dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wmask;
  logic        wb_V, wb_EXC;
  logic [31:0] wb_IR;
  logic [63:0] wb_PC, wb_ALU_RESULT, wb_CSRFD, wb_RFD, wb_MEM_RESULT;
  logic [3:0]  wb_EXC_CAUSE;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .mem_V(mem_V), .mem_IR(mem_IR), .mem_PC(mem_PC), .mem_ALU_RESULT(mem_ALU_RESULT),
    .mem_SR1(mem_SR1), .mem_SR2(mem_SR2), .mem_CSRFD(mem_CSRFD), .mem_RFD(mem_RFD),
    .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_V(wb_V), .wb_IR(wb_IR), .wb_PC(wb_PC), .wb_ALU_RESULT(wb_ALU_RESULT),
    .wb_CSRFD(wb_CSRFD), .wb_RFD(wb_RFD), .wb_MEM_RESULT(wb_MEM_RESULT),
    .wb_EXC(wb_EXC), .wb_EXC_CAUSE(wb_EXC_CAUSE)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Apply one instruction, model its whole lifetime and check every cycle.
  task automatic run_op(input logic [31:0] ir, input logic [63:0] addr, input logic [63:0] sr2,
                        input logic [63:0] rdata, input int ack_wait);
    bit ld, st, illegal, mis, go, timed_out, done, exc;
    int f3, nbytes, off, stalls, exp_stalls, k;
    logic [63:0] szmask, exp_ld, exp_wdata, exp_res;
    logic [7:0]  exp_mask;
    logic [3:0]  cause;

    ld      = (ir[6:0] == 7'h03);
    st      = (ir[6:0] == 7'h23);
    f3      = int'(ir[14:12]);
    nbytes  = 1 << (f3 % 4);
    off     = int'(addr % 8);
    illegal = (ld && f3 == 7) || (st && f3 >= 4);
    mis     = (ld || st) && !illegal && (off % nbytes != 0);
    go      = (ld || st) && !illegal && !mis;
    szmask  = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
    exp_mask  = 8'(((1 << nbytes) - 1) << off);
    exp_wdata = sr2 << (8 * off);
    exp_ld    = (rdata >> (8 * off)) & szmask;
    if (f3 < 4 && exp_ld[8 * nbytes - 1]) exp_ld = exp_ld | ~szmask;

    mem_V = 1'b1; mem_IR = ir; mem_ALU_RESULT = addr; mem_SR2 = sr2;
    mem_PC = rnd64(); mem_SR1 = rnd64(); mem_CSRFD = rnd64(); mem_RFD = rnd64();
    dmem_ack = 1'b0; dmem_rdata = rdata;
    #1;
    check("stall_issue", mem_stall, go);
    check("req_idle", dmem_req, 0);
    @(posedge clk); #1;

    stalls = go ? 1 : 0;
    timed_out = 1'b0;
    if (go) begin
      for (k = 0; k <= TO; k++) begin
        check("req", dmem_req, 1);
        check("we", dmem_we, st);
        check("addr", dmem_addr, {addr[63:3], 3'b000});
        check("wmask", dmem_wmask, st ? exp_mask : 8'd0);
        if (st) check("wdata", dmem_wdata, exp_wdata);
        check("wbv_wait", wb_V, 0);
        dmem_ack = (k == ack_wait);
        #1;
        done = dmem_ack || (k == TO);
        check("stall_acc", mem_stall, !done);
        if (!done) stalls++;
        @(posedge clk); #1;
        if (done) break;
      end
      timed_out = (ack_wait > TO);
      dmem_ack = 1'b0;
    end

    exp_stalls = go ? 1 + ((ack_wait > TO) ? TO : ack_wait) : 0;
    check("stall_cnt", 64'(stalls), 64'(exp_stalls));

    exc   = illegal || mis || timed_out;
    cause = illegal ? 4'd2 : mis ? (ld ? 4'd4 : 4'd6) : timed_out ? (ld ? 4'd5 : 4'd7) : 4'd0;
    exp_res = (ld && go && !timed_out) ? exp_ld : 64'd0;
    check("wb_V", wb_V, 1);
    check("wb_IR", wb_IR, ir);
    check("wb_PC", wb_PC, mem_PC);
    check("wb_ALU", wb_ALU_RESULT, addr);
    check("wb_CSRFD", wb_CSRFD, mem_CSRFD);
    check("wb_RFD", wb_RFD, mem_RFD);
    check("wb_MEM", wb_MEM_RESULT, exp_res);
    check("wb_EXC", wb_EXC, exc);
    check("wb_CAUSE", wb_EXC_CAUSE, cause);
    check("req_done", dmem_req, 0);
    $display("op ir=%08h addr=%016h f3=%0d ack_wait=%0d stalls=%0d exc=%0d cause=%0d res=%016h",
             ir, addr, f3, ack_wait, stalls, wb_EXC, wb_EXC_CAUSE, wb_MEM_RESULT);
    mem_V = 1'b0;
  endtask

  // One idle cycle, optionally with a stray ack, which must be ignored.
  task automatic idle_cycle(input bit stray_ack);
    mem_V = 1'b0; dmem_ack = stray_ack;
    #1;
    check("stall_idle", mem_stall, 0);
    @(posedge clk); #1;
    check("wbv_idle", wb_V, 0);
    check("req_idle2", dmem_req, 0);
    dmem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] ir;
    logic [63:0] addr;
    int kind, aw;

    reset = 1'b1; mem_V = 1'b0; mem_IR = 32'd0; mem_PC = '0; mem_ALU_RESULT = '0;
    mem_SR1 = '0; mem_SR2 = '0; mem_CSRFD = '0; mem_RFD = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wbv", wb_V, 0);
    check("rst_wbir", wb_IR, 0);
    check("rst_wbmem", wb_MEM_RESULT, 0);
    check("rst_exc", wb_EXC, 0);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_wmask", dmem_wmask, 0);
    check("rst_stall", mem_stall, 0);
    reset = 1'b0;

    run_op(32'h0000_0033, 64'd10, 64'd0, 64'd0, 0);
    idle_cycle(1'b0);
    run_op(32'h0030_0083, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 2);
    run_op(32'h0030_4083, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 2);
    run_op(32'h0020_A223, 64'h2004, 64'hDEAD_BEEF, 64'd0, 0);
    run_op(32'h0000_2083, 64'h1002, 64'd0, 64'd0, 0);
    run_op(32'h0000_7083, 64'h1000, 64'd0, 64'd0, 0);
    run_op(32'h0000_0083, 64'h3001, 64'd0, 64'h1122_3344_5566_7788, TO + 5);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // reset during the second ACCESS cycle
    mem_V = 1'b1; mem_IR = 32'h0000_3083; mem_ALU_RESULT = 64'h4000; dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_req_before", dmem_req, 1);
    reset = 1'b1; mem_V = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_req", dmem_req, 0);
    check("rst_mid_wbv", wb_V, 0);
    check("rst_mid_stall", mem_stall, 0);
    $display("reset mid-access: req=%0d wb_V=%0d stall=%0d", dmem_req, wb_V, mem_stall);
    idle_cycle(1'b1);

    for (int i = 0; i < 80; i++) begin
      kind = int'($urandom_range(0, 9));
      ir = $urandom;
      ir[14:12] = 3'($urandom_range(0, 7));
      if (kind < 2)      ir[6:0] = 7'h33;
      else if (kind < 6) ir[6:0] = 7'h03;
      else               ir[6:0] = 7'h23;
      addr = rnd64();
      if ($urandom_range(0, 1) == 0) addr[2:0] = 3'b000;
      aw = ($urandom_range(0, 7) == 0) ? TO + 1 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
      run_op(ir, addr, rnd64(), rnd64(), aw);
      if ($urandom_range(0, 2) == 0) idle_cycle(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
